// File: rtl/alu_test_pkg.sv
// Shared definitions for the ALU pattern sequencer and its response checkers:
// sequencer states and the pattern ROM word layout.
package alu_test_pkg;

    localparam int PAT_W = 9;

    // Pattern word: {ain[1:0], bin[1:0], sel, expected[1:0], mask[1:0]}
    localparam int AIN_MSB  = 8;
    localparam int AIN_LSB  = 7;
    localparam int BIN_MSB  = 6;
    localparam int BIN_LSB  = 5;
    localparam int SEL_BIT  = 4;
    localparam int XPCT_MSB = 3;
    localparam int XPCT_LSB = 2;
    localparam int MASK_MSB = 1;
    localparam int MASK_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_STROBE = 3'd4,
        ST_DONE   = 3'd5
    } seq_state_e;

endpackage

// File: rtl/alu_resp_cmp.sv
// Masked compare of an ALU response against its expected value.
// A zero mask bit makes that response bit a don't-care.
module alu_resp_cmp (
    input  logic [1:0] zout,
    input  logic [1:0] xpct,
    input  logic [1:0] mask,
    output logic       mismatch
);

    assign mismatch = |((zout ^ xpct) & mask);

endmodule

// File: rtl/alu_pattern_seq.sv
// Hardware pattern sequencer for the 2-bit ALU: fetch, apply, settle, strobe, check.
// Define ALU_PATTERN_SEQ_FAIL_LOG_EN to add the first_fail index log.
module alu_pattern_seq
    import alu_test_pkg::*;
#(
    parameter int IDX_W  = 4,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IDX_W-1:0] num_pat,
    output logic             pat_rd,
    output logic [IDX_W-1:0] pat_addr,
    input  logic [PAT_W-1:0] pat_data,
    output logic [1:0]       ain,
    output logic [1:0]       bin,
    output logic             sel,
    input  logic [1:0]       zout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [IDX_W:0]   fail_cnt,
`ifdef ALU_PATTERN_SEQ_FAIL_LOG_EN
    output logic [IDX_W-1:0] first_fail,
`endif
    output logic [2:0]       dbg_state
);

    localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE - 1);
    localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);

    seq_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] num_q, num_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [1:0]       ain_q, ain_d;
    logic [1:0]       bin_q, bin_d;
    logic             sel_q, sel_d;
    logic [1:0]       xpct_q, xpct_d;
    logic [1:0]       mask_q, mask_d;
    logic [IDX_W:0]   fail_cnt_q, fail_cnt_d;
    logic             pass_q, pass_d;
    logic             mismatch;
`ifdef ALU_PATTERN_SEQ_FAIL_LOG_EN
    logic [IDX_W-1:0] first_fail_q, first_fail_d;
`endif

    alu_resp_cmp u_cmp (
        .zout     (zout),
        .xpct     (xpct_q),
        .mask     (mask_q),
        .mismatch (mismatch)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            num_q      <= '0;
            cnt_q      <= '0;
            ain_q      <= '0;
            bin_q      <= '0;
            sel_q      <= 1'b0;
            xpct_q     <= '0;
            mask_q     <= '0;
            fail_cnt_q <= '0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            num_q      <= num_d;
            cnt_q      <= cnt_d;
            ain_q      <= ain_d;
            bin_q      <= bin_d;
            sel_q      <= sel_d;
            xpct_q     <= xpct_d;
            mask_q     <= mask_d;
            fail_cnt_q <= fail_cnt_d;
            pass_q     <= pass_d;
        end
    end

`ifdef ALU_PATTERN_SEQ_FAIL_LOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail_q <= '0;
        end else begin
            first_fail_q <= first_fail_d;
        end
    end

    assign first_fail = first_fail_q;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        num_d      = num_q;
        cnt_d      = cnt_q;
        ain_d      = ain_q;
        bin_d      = bin_q;
        sel_d      = sel_q;
        xpct_d     = xpct_q;
        mask_d     = mask_q;
        fail_cnt_d = fail_cnt_q;
        pass_d     = pass_q;
`ifdef ALU_PATTERN_SEQ_FAIL_LOG_EN
        first_fail_d = first_fail_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    fail_cnt_d = '0;
`ifdef ALU_PATTERN_SEQ_FAIL_LOG_EN
                    first_fail_d = '0;
`endif
                    if (num_pat != '0) begin
                        num_d   = num_pat;
                        idx_d   = '0;
                        pass_d  = 1'b0;
                        state_d = ST_FETCH;
                    end else begin
                        // An empty run trivially passes.
                        pass_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_FETCH: begin
                state_d = ST_LOAD;
            end

            ST_LOAD: begin
                ain_d   = pat_data[AIN_MSB:AIN_LSB];
                bin_d   = pat_data[BIN_MSB:BIN_LSB];
                sel_d   = pat_data[SEL_BIT];
                xpct_d  = pat_data[XPCT_MSB:XPCT_LSB];
                mask_d  = pat_data[MASK_MSB:MASK_LSB];
                cnt_d   = SETTLE_INIT;
                state_d = ST_SETTLE;
            end

            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_STROBE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_STROBE: begin
                if (mismatch) begin
                    if (fail_cnt_q != '1) begin
                        fail_cnt_d = fail_cnt_q + 1'b1;
                    end
`ifdef ALU_PATTERN_SEQ_FAIL_LOG_EN
                    if (fail_cnt_q == '0) begin
                        first_fail_d = idx_q;
                    end
`else
                    // Without the fail log only the count records the mismatch.
`endif
                end
                // pass is settled here so it is already valid during the done pulse.
                if (idx_q == num_q - IDX_ONE) begin
                    pass_d  = (fail_cnt_d == '0);
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_FETCH;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pat_rd    = (state_q == ST_FETCH);
    assign pat_addr  = idx_q;
    assign ain       = ain_q;
    assign bin       = bin_q;
    assign sel       = sel_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign fail_cnt  = fail_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_pattern_seq.sv
// Self-checking bench for alu_pattern_seq: ROM and ALU models, directed plan
// runs plus random pattern sets checked against a per-sequence outcome model.
module tb_alu_pattern_seq;
  localparam int IDX_W  = 4;
  localparam int SETTLE = 2;
  localparam int EXP_W  = 1 + (IDX_W + 1) + IDX_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [IDX_W-1:0] num_pat = '0;
  logic             pat_rd;
  logic [IDX_W-1:0] pat_addr;
  logic [8:0]       pat_data = '0;
  logic [1:0]       ain, bin, zout;
  logic             sel, busy, done, pass;
  logic [IDX_W:0]   fail_cnt;
  logic [2:0]       dbg_state;
`ifdef ALU_PATTERN_SEQ_FAIL_LOG_EN
  logic [IDX_W-1:0] first_fail;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [8:0] rom [16];

  alu_pattern_seq #(.IDX_W(IDX_W), .SETTLE(SETTLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_pat    (num_pat),
    .pat_rd     (pat_rd),
    .pat_addr   (pat_addr),
    .pat_data   (pat_data),
    .ain        (ain),
    .bin        (bin),
    .sel        (sel),
    .zout       (zout),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_cnt   (fail_cnt),
`ifdef ALU_PATTERN_SEQ_FAIL_LOG_EN
    .first_fail (first_fail),
`endif
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / environment ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pat_rd) pat_data <= rom[pat_addr];
  end

  function automatic logic [1:0] alu_ref(input logic [1:0] a, input logic [1:0] b, input logic s);
    return s ? (a & b) : (a | b);
  endfunction

  assign zout = alu_ref(ain, bin, sel);

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Outcome of a whole sequence from the ROM contents: {pass, fail count, first failing index}.
  function automatic logic [EXP_W-1:0] seq_model(input int n);
    int fails = 0;
    int first = 0;
    for (int i = 0; i < n; i++) begin
      logic [8:0] w;
      logic [1:0] z;
      w = rom[i];
      z = alu_ref(w[8:7], w[6:5], w[4]);
      if (((z ^ w[3:2]) & w[1:0]) != 2'b00) begin
        if (fails == 0) first = i;
        fails++;
      end
    end
    if (fails > 31) fails = 31;
    return {(fails == 0), 5'(fails), 4'(first)};
  endfunction

  // ---------------- drivers ----------------
  task automatic load_plan(input logic [1:0] p1_xpct, input logic [1:0] p1_mask);
    rom[0] = 9'b11101_10_11;
    rom[1] = {5'b00111, p1_xpct, p1_mask};
    rom[2] = 9'b11111_11_11;
  endtask

  task automatic load_random(input int n, input bit all_fail);
    for (int i = 0; i < n; i++) begin
      logic [1:0] a, b, x, m, z;
      logic s;
      a = 2'($urandom_range(0, 3));
      b = 2'($urandom_range(0, 3));
      s = 1'($urandom_range(0, 1));
      z = alu_ref(a, b, s);
      if (all_fail) begin
        x = ~z;
        m = 2'b11;
      end else begin
        m = 2'($urandom_range(0, 3));
        x = ($urandom_range(0, 2) == 0) ? (z ^ 2'($urandom_range(1, 3))) : z;
      end
      rom[i] = {a, b, s, x, m};
    end
  endtask

  task automatic run_and_check(input string tag, input int n, input bit dup_start);
    int cyc, reads, addr_err, busy_bad;
    logic [EXP_W-1:0] e;
    exp_q.push_back(seq_model(n));
    reads = 0; addr_err = 0; busy_bad = 0;
    @(negedge clk);
    start = 1'b1;
    num_pat = IDX_W'(n);
    @(negedge clk);
    start = 1'b0;
    num_pat = IDX_W'($urandom_range(0, 15));
    cyc = 1;
    while (!done && cyc < 400) begin
      if (pat_rd) begin
        if (pat_addr != IDX_W'(reads)) addr_err++;
        reads++;
      end
      if (!busy) busy_bad++;
      if (dup_start && cyc == 5) begin
        start = 1'b1;
        num_pat = 4'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    e = exp_q.pop_front();
    check({tag, " latency"}, 32'(cyc), 32'(1 + n * (3 + SETTLE)));
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " pass"}, 32'(pass), 32'(e[EXP_W-1]));
    check({tag, " fail_cnt"}, 32'(fail_cnt), 32'(e[EXP_W-2 -: IDX_W+1]));
`ifdef ALU_PATTERN_SEQ_FAIL_LOG_EN
    check({tag, " first_fail"}, 32'(first_fail), 32'(e[IDX_W-1:0]));
`endif
    check({tag, " reads"}, 32'(reads), 32'(n));
    check({tag, " addr_order"}, 32'(addr_err), 32'd0);
    check({tag, " busy_during_run"}, 32'(busy_bad), 32'd0);
    if (n > 0) begin
      logic [8:0] last;
      last = rom[n-1];
      check({tag, " hold_drives"}, 32'({ain, bin, sel}), 32'(last[8:4]));
    end
    @(negedge clk);
    check({tag, " done_pulse_end"}, 32'({done, busy}), 32'd0);
    check({tag, " pass_held"}, 32'(pass), 32'(e[EXP_W-1]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ctl"}, 32'({pat_rd, busy, done, pass}), 32'd0);
    check({tag, " pat_addr"}, 32'(pat_addr), 32'd0);
    check({tag, " drives"}, 32'({ain, bin, sel}), 32'd0);
    check({tag, " fail_cnt"}, 32'(fail_cnt), 32'd0);
`ifdef ALU_PATTERN_SEQ_FAIL_LOG_EN
    check({tag, " first_fail"}, 32'(first_fail), 32'd0);
`endif
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 16; i++) rom[i] = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    load_plan(2'b00, 2'b11);
    run_and_check("plan_pass", 3, 1'b0);

    load_plan(2'b01, 2'b11);
    run_and_check("plan_fail_p1", 3, 1'b0);
    check("plan_fail_p1 pass_value", 32'(pass), 32'd0);

    load_plan(2'b01, 2'b00);
    run_and_check("plan_masked", 3, 1'b0);

    run_and_check("empty_run", 0, 1'b0);

    // Abort during the settle window of pattern 1, after pattern 0 has already failed.
    load_random(3, 1'b1);
    @(negedge clk);
    start = 1'b1;
    num_pat = 4'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("abort pre_reset fail_cnt", 32'(fail_cnt), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    begin
      int done_seen = 0;
      repeat (3) begin
        @(negedge clk);
        if (done) done_seen++;
      end
      check("abort no_done", 32'(done_seen), 32'd0);
    end
    rst_n = 1'b1;
    load_plan(2'b00, 2'b11);
    run_and_check("after_abort", 3, 1'b0);

    load_random(15, 1'b1);
    run_and_check("all_fail_15", 15, 1'b1);

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 15);
      load_random(n, 1'b0);
      run_and_check($sformatf("random_%0d", r), n, ($urandom_range(0, 1) == 1));
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_pattern_seq.md
# alu_pattern_seq

On-chip pattern sequencer for the 2-bit `alu` datapath (`ain`, `bin`, `sel` → `zout`). It fetches stored test vectors from a synchronous pattern ROM and applies each one to the ALU. After a programmable settle time it strobes `zout` and checks it, under a per-bit mask, against the expected value. It reports pass/fail, a fail count and the first failing pattern, so the capture flow from the ATPG pattern sets runs in hardware instead of in a testbench.

## Interface
- `IDX_W`, default 4: pattern index width; up to 2^IDX_W patterns.
- `SETTLE`, default 2: cycles between driving the ALU and strobing `zout`. Legal range is 1 to 15.
- `clk` in 1: single clock. All state is on its rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle request to run a sequence. Sampled only in IDLE.
- `num_pat` in IDX_W: number of patterns to run. Sampled with `start`.
- `pat_rd` out 1: ROM read enable.
- `pat_addr` out IDX_W: ROM address.
- `pat_data` in 9: ROM word. Bit mapping:
  - [8:7] = `ain`
  - [6:5] = `bin`
  - [4] = `sel`
  - [3:2] = expected {`zout[1]`,`zout[0]`}
  - [1:0] = mask {`zout[1]`,`zout[0]`}
  - Data is valid the cycle after `pat_rd`.
- `ain` out 2, `bin` out 2, `sel` out 1: registered drives to the ALU.
- `zout` in 2: ALU response.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse at the end of a sequence.
- `pass` out 1: high when the last completed sequence had zero fails. Held until the next accepted `start`.
- `fail_cnt` out IDX_W+1: saturating mismatch count.
- `first_fail` out IDX_W: index of the first mismatching pattern. Only present with the macro, see Configuration.

## Operation
- States: IDLE, FETCH, LOAD, SETTLE, STROBE, DONE.
- **IDLE**
  - `start`=1 and `num_pat`≠0: latch `num_pat`, clear `idx`, `fail_cnt`, `pass` and `first_fail`, go to FETCH.
  - `start`=1 and `num_pat`=0: go straight to DONE with `pass`=1.
- **FETCH:** `pat_rd`=1, `pat_addr`=`idx`. Go to LOAD.
- **LOAD:**
  - Register `ain`/`bin`/`sel` from `pat_data`.
  - Capture expected and mask into internal registers.
  - Load the settle counter with SETTLE−1. Go to SETTLE.
- **SETTLE:** decrement the counter. At 0, go to STROBE.
- **STROBE:**
  - Mismatch = |((`zout` ^ expected) & mask).
  - On mismatch, increment `fail_cnt`; it saturates at all-ones.
  - If `idx` = latched count − 1, go to DONE. Otherwise increment `idx` and go to FETCH.
  - A mask of 00 never fails.
- **DONE:**
  - `done`=1 for this cycle.
  - `pass` = (`fail_cnt`==0), counting any mismatch from the final STROBE.
  - Go to IDLE.
- `start` while not in IDLE is ignored. `num_pat` changes after acceptance have no effect.
- ALU drives hold their last pattern value after DONE and in IDLE.

## Timing
- Reset values:
  - state = IDLE
  - `ain`=`bin`=0, `sel`=0
  - `pat_rd`=0, `pat_addr`=0
  - `busy`=0, `done`=0, `pass`=0
  - `fail_cnt`=0, `first_fail`=0
- Reset asserted mid-sequence aborts immediately to reset values. No `done` is produced.
- Cycles per pattern = 3 + SETTLE.
- Sequence latency from `start` to `done` = 1 + N·(3+SETTLE) cycles. With `num_pat`=0 it is 1 cycle.
- `zout` is sampled at the clock edge leaving STROBE. This is SETTLE+1 edges after the drives change.
- ROM read latency is exactly 1 cycle. No wait states are supported.
- Index wrap: `num_pat` = 2^IDX_W is not representable, so the maximum run is 2^IDX_W−1 patterns.

## Configuration
- `ALU_PATTERN_SEQ_FAIL_LOG_EN` defined:
  - The `first_fail` port exists.
  - It latches `idx` on the first STROBE mismatch of a sequence and holds it until the next accepted `start`.
- Not defined: the port and its register are removed. All other behaviour is identical.

## Structure
- The shared package `alu_test_pkg` holds:
  - the state enum
  - the `pat_data` field bit positions (AIN_MSB/LSB, BIN_MSB/LSB, SEL_BIT, XPCT_MSB/LSB, MASK_MSB/LSB)
  - PAT_W = 9
- One sub-module, `alu_resp_cmp`: a combinational masked compare of `zout`/expected/mask to a mismatch flag. Reused by other pattern checkers.

## Test plan
- ROM = {11101_10_11, 00111_00_11, 11111_11_11} with an AND-on-sel=1 ALU model, `num_pat`=3, SETTLE=2. Required: `done` 16 cycles after `start`, `pass`=1, `fail_cnt`=0.
- Same ROM with pattern 1 expected set to 01. Required: `pass`=0, `fail_cnt`=1, `first_fail`=1 (macro on).
- Pattern 1 expected set to 01 but mask set to 00. Required: `pass`=1, `fail_cnt`=0.
- `num_pat`=0. Required: `done` on the cycle after `start`, `pass`=1, `pat_rd` never asserted.
- `rst_n` pulsed low during the SETTLE of pattern 1. Required: all outputs at reset values at once, no `done`. A new `start` afterwards runs the full sequence.
- 15 patterns all mismatching, IDX_W=4. Required: `fail_cnt`=15. A second `start` pulse while `busy` has no effect.
